// File: rtl/npn4_pkg.sv
// Shared definitions for the 4-input NPN canonizer: permutation table, FSM states and
// the transform function used by both the datapath and its reference model.
package npn4_pkg;

   localparam int unsigned N_TRANSFORMS = 768;
   localparam int unsigned N_PERMS      = 24;

   // Element j of a perm_t is PERM[p][j]; literals below are written {e3, e2, e1, e0}.
   typedef logic [3:0][1:0] perm_t;

   typedef enum logic [1:0] {
      StIdle,
      StSearch,
      StDone
   } state_e;

   localparam perm_t PERM [N_PERMS] = '{
      {2'd3, 2'd2, 2'd1, 2'd0}, {2'd2, 2'd3, 2'd1, 2'd0}, {2'd3, 2'd1, 2'd2, 2'd0},
      {2'd1, 2'd3, 2'd2, 2'd0}, {2'd2, 2'd1, 2'd3, 2'd0}, {2'd1, 2'd2, 2'd3, 2'd0},
      {2'd3, 2'd2, 2'd0, 2'd1}, {2'd2, 2'd3, 2'd0, 2'd1}, {2'd3, 2'd0, 2'd2, 2'd1},
      {2'd0, 2'd3, 2'd2, 2'd1}, {2'd2, 2'd0, 2'd3, 2'd1}, {2'd0, 2'd2, 2'd3, 2'd1},
      {2'd3, 2'd1, 2'd0, 2'd2}, {2'd1, 2'd3, 2'd0, 2'd2}, {2'd3, 2'd0, 2'd1, 2'd2},
      {2'd0, 2'd3, 2'd1, 2'd2}, {2'd1, 2'd0, 2'd3, 2'd2}, {2'd0, 2'd1, 2'd3, 2'd2},
      {2'd2, 2'd1, 2'd0, 2'd3}, {2'd1, 2'd2, 2'd0, 2'd3}, {2'd2, 2'd0, 2'd1, 2'd3},
      {2'd0, 2'd2, 2'd1, 2'd3}, {2'd1, 2'd0, 2'd2, 2'd3}, {2'd0, 2'd1, 2'd2, 2'd3}
   };

   function automatic logic [15:0] apply_npn(input logic [15:0] tt, input logic [4:0] p,
                                             input logic [3:0] n, input logic o);
      logic [15:0] cand;
      logic [3:0]  idx;
      logic [3:0]  k;
      perm_t       pm;
      pm = PERM[p];
      for (int i = 0; i < 16; i++) begin
         idx = 4'(i);
         for (int j = 0; j < 4; j++) begin
            k[j] = idx[pm[j]] ^ n[j];
         end
         cand[i] = o ^ tt[k];
      end
      return cand;
   endfunction

endpackage

// File: rtl/npn4_transform.sv
// One NPN transform lane: applies (perm, neg, oneg) to a truth table, purely combinational.
module npn4_transform
   import npn4_pkg::*;
(
   input  logic [15:0] tt_i,
   input  logic [4:0]  perm_i,
   input  logic [3:0]  neg_i,
   input  logic        oneg_i,
   output logic [15:0] cand_o
);

   assign cand_o = apply_npn(tt_i, perm_i, neg_i, oneg_i);

endmodule

// File: rtl/npn4_canonizer.sv
// Sequential exact NPN canonizer: sweeps all 768 transforms, NEG_PAR per cycle, and keeps
// the smallest candidate with the lowest transform index on ties.
module npn4_canonizer
   import npn4_pkg::*;
#(
   parameter int unsigned NEG_PAR = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid_i,
   output logic        in_ready_o,
   input  logic [15:0] in_tt_i,
   output logic        out_valid_o,
   input  logic        out_ready_i,
   output logic [15:0] out_tt_o,
   output logic [4:0]  out_perm_o,
   output logic [3:0]  out_neg_o,
   output logic        out_oneg_o,
   output logic        busy_o
);

   localparam int unsigned N_BATCH = N_TRANSFORMS / NEG_PAR;
   localparam int unsigned CntW    = $clog2(N_BATCH);
   localparam int unsigned TW      = $clog2(N_TRANSFORMS);

   if (!(NEG_PAR == 1 || NEG_PAR == 2 || NEG_PAR == 4 || NEG_PAR == 8 || NEG_PAR == 16 ||
         NEG_PAR == 32)) begin : g_bad_neg_par
      $error("npn4_canonizer: NEG_PAR must be one of 1, 2, 4, 8, 16, 32");
   end

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [15:0]     tt_q, tt_d;
   logic [15:0]     best_tt_q, best_tt_d;
   logic [TW-1:0]   best_t_q, best_t_d;
   logic            best_vld_q, best_vld_d;

   logic [15:0]     cand   [NEG_PAR];
   logic [TW-1:0]   cand_t [NEG_PAR];
   logic [15:0]     sel_tt;
   logic [TW-1:0]   sel_t;
   logic            sel_vld;

   for (genvar g = 0; g < NEG_PAR; g++) begin : g_lane
      assign cand_t[g] = TW'(cnt_q) * TW'(NEG_PAR) + TW'(g);

      npn4_transform u_xform (
         .tt_i   (tt_q),
         .perm_i (cand_t[g][9:5]),
         .neg_i  (cand_t[g][4:1]),
         .oneg_i (cand_t[g][0]),
         .cand_o (cand[g])
      );
   end

   // Lanes are folded in ascending t so strict less-than keeps the earliest winner.
   always_comb begin
      sel_tt  = best_tt_q;
      sel_t   = best_t_q;
      sel_vld = best_vld_q;
      for (int g = 0; g < NEG_PAR; g++) begin
         if (!sel_vld || (cand[g] < sel_tt)) begin
            sel_tt  = cand[g];
            sel_t   = cand_t[g];
            sel_vld = 1'b1;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      tt_d       = tt_q;
      best_tt_d  = best_tt_q;
      best_t_d   = best_t_q;
      best_vld_d = best_vld_q;
      unique case (state_q)
         StIdle: begin
            if (in_valid_i) begin
               state_d    = StSearch;
               tt_d       = in_tt_i;
               cnt_d      = '0;
               best_tt_d  = 16'hFFFF;
               best_vld_d = 1'b0;
            end
         end
         StSearch: begin
            best_tt_d  = sel_tt;
            best_t_d   = sel_t;
            best_vld_d = sel_vld;
            if (cnt_q == CntW'(N_BATCH - 1)) begin
               state_d = StDone;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StDone: begin
            if (out_ready_i) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         tt_q       <= '0;
         best_tt_q  <= '0;
         best_t_q   <= '0;
         best_vld_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         tt_q       <= tt_d;
         best_tt_q  <= best_tt_d;
         best_t_q   <= best_t_d;
         best_vld_q <= best_vld_d;
      end
   end

   assign in_ready_o  = (state_q == StIdle);
   assign busy_o      = (state_q != StIdle);
   assign out_valid_o = (state_q == StDone);
   assign out_tt_o    = best_tt_q;
   assign out_perm_o  = best_t_q[9:5];
   assign out_neg_o   = best_t_q[4:1];
   assign out_oneg_o  = best_t_q[0];

endmodule

// File: tb/tb_npn4_canonizer.sv
// Randomised bench for npn4_canonizer at NEG_PAR 1, 4 and 32 against an exhaustive
// reference model, with back-pressure, ignored inputs and mid-search reset.
module tb_npn4_canonizer;

   localparam int NCFG = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int cycle    = 0;
   bit blk_done [NCFG];

   always @(posedge clk) cycle <= cycle + 1;

   task automatic check(input string name, input int np, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s (NEG_PAR=%0d) at cycle %0d: got 0x%0h, want 0x%0h",
                  name, np, cycle, act, exp);
      end
   endtask

   // Exhaustive canonical form; returns {t[9:0], tt[15:0]}.
   function automatic logic [25:0] ref_canon(input logic [15:0] tt);
      int          perms [24][4];
      int          np;
      int          p, n, o, k;
      int          best_t;
      logic [15:0] best;
      logic [15:0] cand;
      np     = 0;
      best   = 16'hFFFF;
      best_t = -1;
      // Nested ascending loops yield the permutations in lexicographic order.
      for (int a = 0; a < 4; a++)
         for (int b = 0; b < 4; b++)
            for (int c = 0; c < 4; c++)
               for (int d = 0; d < 4; d++)
                  if (a != b && a != c && a != d && b != c && b != d && c != d) begin
                     perms[np] = '{a, b, c, d};
                     np++;
                  end
      for (int t = 0; t < 768; t++) begin
         p = t / 32;
         n = (t / 2) % 16;
         o = t % 2;
         for (int i = 0; i < 16; i++) begin
            k = 0;
            for (int j = 0; j < 4; j++) begin
               k += (((i >> perms[p][j]) & 1) ^ ((n >> j) & 1)) << j;
            end
            cand[i] = tt[k] ^ (o == 1);
         end
         if (best_t < 0 || cand < best) begin
            best   = cand;
            best_t = t;
         end
      end
      return {10'(best_t), best};
   endfunction

   for (genvar gi = 0; gi < NCFG; gi++) begin : g_cfg
      localparam int NP     = (gi == 0) ? 1 : (gi == 1) ? 4 : 32;
      localparam int NB     = 768 / NP;
      localparam int N_RAND = (gi == 0) ? 40 : 200;
      localparam int RST_AT = (NB > 300) ? 300 : NB / 2;

      logic        rst       = 1'b1;
      logic        in_valid  = 1'b0;
      logic        out_ready = 1'b0;
      logic [15:0] in_tt     = 16'h0;
      logic        in_ready, out_valid, busy, out_oneg;
      logic [15:0] out_tt;
      logic [4:0]  out_perm;
      logic [3:0]  out_neg;

      npn4_canonizer #(.NEG_PAR(NP)) u_dut (
         .clk         (clk),
         .rst         (rst),
         .in_valid_i  (in_valid),
         .in_ready_o  (in_ready),
         .in_tt_i     (in_tt),
         .out_valid_o (out_valid),
         .out_ready_i (out_ready),
         .out_tt_o    (out_tt),
         .out_perm_o  (out_perm),
         .out_neg_o   (out_neg),
         .out_oneg_o  (out_oneg),
         .busy_o      (busy)
      );

      // Model: phase 0 idle, 1 search (left edges to go), 2 done.
      int          ph      = 0;
      int          left    = 0;
      bit          chk_out = 1'b0;
      bit          armed   = 1'b0;
      logic [25:0] r_q     = '0;
      logic [15:0] acc_tt  = '0;
      logic [15:0] e_tt;
      int          e_t;

      assign e_tt = r_q[15:0];
      assign e_t  = int'(r_q[25:16]);

      always @(posedge clk) begin
         if (rst) begin
            ph      <= 0;
            chk_out <= 1'b1;
            r_q     <= '0;
         end else begin
            case (ph)
               0: if (in_valid) begin
                  ph      <= 1;
                  left    <= NB;
                  chk_out <= 1'b0;
                  acc_tt  <= in_tt;
                  r_q     <= ref_canon(in_tt);
               end
               1: begin
                  left <= left - 1;
                  if (left == 1) begin
                     ph      <= 2;
                     chk_out <= 1'b1;
                  end
               end
               default: if (out_ready) begin
                  ph      <= 0;
                  chk_out <= 1'b0;
               end
            endcase
         end
      end

      always @(negedge clk) begin
         if (armed) begin
            check("out_valid", NP, out_valid, ph == 2);
            check("in_ready", NP, in_ready, ph == 0);
            check("busy", NP, busy, ph != 0);
            if (chk_out) begin
               check("out_tt", NP, out_tt, e_tt);
               check("out_perm", NP, out_perm, e_t / 32);
               check("out_neg", NP, out_neg, (e_t / 2) % 16);
               check("out_oneg", NP, out_oneg, e_t % 2);
            end
            if (ph == 2) begin
               check("perm_range", NP, out_perm <= 5'd23, 1'b1);
               check("tt_le_in", NP, out_tt <= acc_tt, 1'b1);
            end
         end
      end

      task automatic run_job(input logic [15:0] tt, input int hold, input bit poke,
                             input int rst_at);
         int cyc;
         cyc = 0;
         while (!in_ready && cyc < 20) begin
            @(negedge clk);
            cyc++;
         end
         check("idle_wait", NP, in_ready, 1'b1);
         in_tt    = tt;
         in_valid = 1'b1;
         @(negedge clk);
         in_valid = 1'b0;
         in_tt    = 16'($urandom);
         cyc      = 0;
         while (!out_valid && cyc < NB + 5) begin
            in_valid = 1'b0;
            if (poke && cyc == 3) begin
               in_valid = 1'b1;
               in_tt    = ~tt;
            end
            if (rst_at > 0 && cyc == rst_at) rst = 1'b1;
            @(negedge clk);
            cyc++;
            if (rst) begin
               rst = 1'b0;
               return;
            end
         end
         in_valid = 1'b0;
         check("latency", NP, cyc, NB);
         for (int h = 0; h < hold; h++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_tt    = 16'($urandom);
            @(negedge clk);
         end
         in_valid  = 1'b0;
         out_ready = 1'b1;
         @(negedge clk);
         out_ready = 1'b0;
      endtask

      initial begin
         repeat (2) @(negedge clk);
         rst   = 1'b0;
         armed = 1'b1;
         run_job(16'h0000, 0, 1'b0, 0);
         run_job(16'hFFFF, 2, 1'b0, 0);
         run_job(16'hAAAA, 0, 1'b0, 0);
         run_job(16'h07BC, 50, 1'b1, 0);
         run_job(16'h1234, 0, 1'b0, RST_AT);
         run_job(16'hFFFF, 1, 1'b0, 0);
         for (int r = 0; r < N_RAND; r++) begin
            run_job(16'($urandom), $urandom_range(0, 3), $urandom_range(0, 7) == 0, 0);
         end
         blk_done[gi] = 1'b1;
      end
   end

   initial begin
      logic [25:0] r;
      int          ndone;
      r = ref_canon(16'h0000);
      check("ref_0000", 0, r, {10'd0, 16'h0000});
      r = ref_canon(16'hFFFF);
      check("ref_ffff", 0, r, {10'd1, 16'h0000});
      r = ref_canon(16'hAAAA);
      check("ref_aaaa", 0, r, {10'd577, 16'h00FF});
      r = ref_canon(16'h00FF);
      check("ref_00ff", 0, r, {10'd0, 16'h00FF});
      ndone = 0;
      while (ndone < NCFG && cycle < 90000) begin
         @(negedge clk);
         ndone = 0;
         for (int i = 0; i < NCFG; i++) ndone += int'(blk_done[i]);
      end
      check("all_configs_done", 0, ndone, NCFG);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
